fp16_operand_framer: RTL and testbench

- Upstream stage of the approximate FP16 log-multiplier.
- Assembles two binary16 operands (A, B) from a byte-serial pin stream, low byte first, one A byte and one B byte per beat.
- Classifies each operand, flushes subnormals to signed zero, and presents the operand pair over a valid/ready handshake.
- Double-buffered (staging + output register), so a new frame can be received while the multiplier has not yet taken the previous pair.

---
 rtl/fp16_pkg.sv | 26 ++
 rtl/fp16_classify.sv | 32 +++
 rtl/fp16_operand_framer.sv | 151 +++++++++++++++
 tb/tb_fp16_operand_framer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/fp16_pkg.sv
// Shared definitions for the FP16 log-multiplier front end.
//   - binary16 field positions and exponent constants
//   - operand class encoding (2 bits)
//   - operand framer FSM state encoding
package fp16_pkg;

  localparam int SIGN_BIT = 15;
  localparam int EXP_MSB  = 14;
  localparam int EXP_LSB  = 10;
  localparam int MAN_MSB  = 9;
  localparam int EXP_BIAS = 15;
  localparam logic [4:0] EXP_MAX = 5'd31;

  typedef enum logic [1:0] {
    CLS_NORMAL = 2'd0,
    CLS_ZERO   = 2'd1,
    CLS_INF    = 2'd2,
    CLS_NAN    = 2'd3
  } fp16_class_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HALF = 1'b1
  } framer_state_e;

endpackage

// File: rtl/fp16_classify.sv
// Combinational binary16 operand classifier.
//   din  : raw binary16 operand
//   dout : operand with subnormals flushed to signed zero, else unchanged
//   cls  : NORMAL / ZERO / INF / NAN
module fp16_classify
  import fp16_pkg::*;
(
  input  logic [15:0]  din,
  output logic [15:0]  dout,
  output fp16_class_e  cls
);

  logic [4:0] exp_f;
  logic [9:0] man_f;

  assign exp_f = din[EXP_MSB:EXP_LSB];
  assign man_f = din[MAN_MSB:0];

  always_comb begin
    dout = din;
    cls  = CLS_NORMAL;
    if (exp_f == 5'd0) begin
      // Zero and subnormal both collapse to a signed zero.
      cls  = CLS_ZERO;
      dout = {din[SIGN_BIT], 15'b0};
    end else if (exp_f == EXP_MAX) begin
      // NaN payload is passed through untouched.
      cls = (man_f == 10'd0) ? CLS_INF : CLS_NAN;
    end
  end

endmodule

// File: rtl/fp16_operand_framer.sv
// Byte-serial FP16 operand framer.
// Collects A/B operands low byte first (one A and one B byte per beat),
// classifies them, and hands the pair downstream over valid/ready through
// a staging register plus an output register.
//   clk, rst                 : clock, asynchronous active-high reset
//   byte_valid/byte_a/byte_b : beat input
//   byte_ready               : beat accepted this cycle (staging not full)
//   op_valid/op_ready        : operand pair handshake
//   op_a/op_b                : flushed operands
//   a_class/b_class          : operand classes
//   err_timeout              : one-cycle pulse when a half frame is dropped
module fp16_operand_framer
  import fp16_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        byte_valid,
  input  logic [7:0]  byte_a,
  input  logic [7:0]  byte_b,
  output logic        byte_ready,
  output logic        op_valid,
  input  logic        op_ready,
  output logic [15:0] op_a,
  output logic [15:0] op_b,
  output logic [1:0]  a_class,
  output logic [1:0]  b_class,
  output logic        err_timeout
);

  localparam logic [CNT_W:0] TO_VAL = TIMEOUT_CYCLES[CNT_W:0];

  framer_state_e state, state_nxt;
  logic [7:0]       lo_a, lo_b;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W:0]   cnt_plus;
  logic             accept, frame_done, timeout_hit;
  logic             hs, load_out, load_stg, move_stg;

  logic             stg_full;
  logic [15:0]      stg_a, stg_b;
  fp16_class_e      stg_ca, stg_cb;

  logic [15:0]      val_a, val_b;
  fp16_class_e      cls_a, cls_b;

  // byte_ready depends only on registered state, never on op_ready.
  assign byte_ready = !stg_full;
  assign accept     = byte_valid & byte_ready;
  assign cnt_plus   = {1'b0, cnt} + {{CNT_W{1'b0}}, 1'b1};

  // Assembly FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    frame_done  = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      ST_IDLE: if (accept) state_nxt = ST_HALF;
      ST_HALF: begin
        if (accept) begin
          frame_done = 1'b1;
          state_nxt  = ST_IDLE;
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_plus == TO_VAL)) begin
          timeout_hit = 1'b1;
          state_nxt   = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Idle counter keeps running in HALF even while staging backpressures beats.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      err_timeout <= 1'b0;
    end else begin
      err_timeout <= timeout_hit;
      if (state == ST_IDLE && accept)      cnt <= '0;
      else if (state == ST_HALF && !accept) cnt <= cnt_plus[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (state == ST_IDLE && accept) begin
      lo_a <= byte_a;
      lo_b <= byte_b;
    end
  end

  // Classification of the frame being completed
  fp16_classify u_cls_a (.din({byte_a, lo_a}), .dout(val_a), .cls(cls_a));
  fp16_classify u_cls_b (.din({byte_b, lo_b}), .dout(val_b), .cls(cls_b));

  // Routing: output register if free (or draining now), otherwise staging.
  // A frame can only complete while staging is empty, so load_stg and
  // move_stg never coincide.
  assign hs       = op_valid & op_ready;
  assign load_out = frame_done & (!op_valid | hs);
  assign load_stg = frame_done & op_valid & !hs;
  assign move_stg = hs & stg_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stg_full <= 1'b0;
      op_valid <= 1'b0;
    end else begin
      if (load_stg)      stg_full <= 1'b1;
      else if (move_stg) stg_full <= 1'b0;
      if (load_out | move_stg) op_valid <= 1'b1;
      else if (hs)             op_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (load_stg) begin
      stg_a  <= val_a;
      stg_b  <= val_b;
      stg_ca <= cls_a;
      stg_cb <= cls_b;
    end
  end

  // Output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a    <= '0;
      op_b    <= '0;
      a_class <= '0;
      b_class <= '0;
    end else if (load_out) begin
      op_a    <= val_a;
      op_b    <= val_b;
      a_class <= cls_a;
      b_class <= cls_b;
    end else if (move_stg) begin
      op_a    <= stg_a;
      op_b    <= stg_b;
      a_class <= stg_ca;
      b_class <= stg_cb;
    end
  end

endmodule

// File: tb/tb_fp16_operand_framer.sv
// Self-checking bench for fp16_operand_framer: directed vector table,
// hand-written multi-cycle sequences, and random traffic compared against
// a queue-based reference model.
module tb_fp16_operand_framer;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        byte_valid;
  logic [7:0]  byte_a, byte_b;
  logic        byte_ready;
  logic        op_valid;
  logic        op_ready;
  logic [15:0] op_a, op_b;
  logic [1:0]  a_class, b_class;
  logic        err_timeout;

  int checks = 0;
  int errors = 0;

  fp16_operand_framer #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .byte_valid(byte_valid), .byte_a(byte_a), .byte_b(byte_b),
    .byte_ready(byte_ready),
    .op_valid(op_valid), .op_ready(op_ready),
    .op_a(op_a), .op_b(op_b), .a_class(a_class), .b_class(b_class),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  // Reference model: pending pairs as a queue (head = what is on the output)
  logic [35:0] m_q[$];
  bit          m_half;
  logic [7:0]  m_lo_a, m_lo_b;
  int          m_idle;
  bit          m_err;

  function automatic logic [17:0] ref_cls(logic [15:0] x);
    int e, m;
    e = (int'(x) / 1024) % 32;
    m = int'(x) % 1024;
    if (e == 0)  return {2'd1, x & 16'h8000};
    if (e == 31) return (m == 0) ? {2'd2, x} : {2'd3, x};
    return {2'd0, x};
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_half = 0;
    m_err  = 0;
    m_idle = 0;
  endtask

  task automatic model_step(bit bv, logic [7:0] ba, logic [7:0] bb, bit rdy);
    bit acc, hs, done;
    logic [15:0] fa, fb;
    logic [17:0] ra, rb;
    acc  = bv && (m_q.size() < 2);
    hs   = rdy && (m_q.size() > 0);
    done = 0;
    m_err = 0;
    fa = '0;
    fb = '0;
    if (!m_half) begin
      if (acc) begin
        m_lo_a = ba; m_lo_b = bb; m_idle = 0; m_half = 1;
      end
    end else if (acc) begin
      fa = {ba, m_lo_a}; fb = {bb, m_lo_b}; done = 1; m_half = 0;
    end else begin
      m_idle++;
      if (m_idle == TO) begin
        m_half = 0; m_err = 1;
      end
    end
    if (hs) void'(m_q.pop_front());
    if (done) begin
      ra = ref_cls(fa);
      rb = ref_cls(fb);
      m_q.push_back({ra[17:16], rb[17:16], ra[15:0], rb[15:0]});
    end
  endtask

  task automatic model_check();
    logic [35:0] e;
    chk("byte_ready", 32'(byte_ready), 32'(m_q.size() < 2));
    chk("op_valid", 32'(op_valid), 32'(m_q.size() > 0));
    chk("err_timeout", 32'(err_timeout), 32'(m_err));
    if (m_q.size() > 0) begin
      e = m_q[0];
      chk("op_a", 32'(op_a), 32'(e[31:16]));
      chk("op_b", 32'(op_b), 32'(e[15:0]));
      chk("a_class", 32'(a_class), 32'(e[35:34]));
      chk("b_class", 32'(b_class), 32'(e[33:32]));
    end
  endtask

  // One clock: drive away from the edge, advance model, sample 1ns after edge.
  task automatic cyc(bit bv, logic [7:0] ba, logic [7:0] bb, bit rdy);
    byte_valid = bv;
    byte_a     = ba;
    byte_b     = bb;
    op_ready   = rdy;
    model_step(bv, ba, bb, rdy);
    @(posedge clk);
    #1;
    model_check();
  endtask

  task automatic send(logic [15:0] a, logic [15:0] b, bit rdy);
    cyc(1, a[7:0], b[7:0], rdy);
    cyc(1, a[15:8], b[15:8], rdy);
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    byte_valid = 1'b1;
    byte_a     = 8'h3C;
    byte_b     = 8'h3C;
    op_ready   = 1'b0;
    #1;
    chk("rst op_valid", 32'(op_valid), 32'd0);
    chk("rst byte_ready", 32'(byte_ready), 32'd1);
    chk("rst err", 32'(err_timeout), 32'd0);
    chk("rst op_a", 32'(op_a), 32'd0);
    chk("rst class", 32'({a_class, b_class}), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst        = 1'b0;
    byte_valid = 1'b0;
  endtask

  typedef struct {
    logic [15:0] a, b, ea, eb;
    logic [1:0]  ca, cb;
  } vec_t;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl[6];
    tbl[0] = '{16'h3C00, 16'h4000, 16'h3C00, 16'h4000, 2'd0, 2'd0};
    tbl[1] = '{16'h8001, 16'h0000, 16'h8000, 16'h0000, 2'd1, 2'd1};
    tbl[2] = '{16'h7C00, 16'h7E00, 16'h7C00, 16'h7E00, 2'd2, 2'd3};
    tbl[3] = '{16'h03FF, 16'hFC00, 16'h0000, 16'hFC00, 2'd1, 2'd2};
    tbl[4] = '{16'h7BFF, 16'h0400, 16'h7BFF, 16'h0400, 2'd0, 2'd0};
    tbl[5] = '{16'hFC01, 16'h8000, 16'hFC01, 16'h8000, 2'd3, 2'd1};

    do_reset();

    // Directed vectors: result one cycle after the high beat
    for (int i = 0; i < 6; i++) begin
      send(tbl[i].a, tbl[i].b, 1'b1);
      chk($sformatf("vec%0d valid", i), 32'(op_valid), 32'd1);
      chk($sformatf("vec%0d op_a", i), 32'(op_a), 32'(tbl[i].ea));
      chk($sformatf("vec%0d op_b", i), 32'(op_b), 32'(tbl[i].eb));
      chk($sformatf("vec%0d cls", i), 32'({a_class, b_class}), 32'({tbl[i].ca, tbl[i].cb}));
      cyc(0, 8'h00, 8'h00, 1);
      chk($sformatf("vec%0d drained", i), 32'(op_valid), 32'd0);
    end

    // Backpressure: F1 on output, F2 in staging, F3 stalls
    send(16'h3C00, 16'h4000, 1'b0);
    send(16'h4200, 16'hC000, 1'b0);
    chk("bp byte_ready", 32'(byte_ready), 32'd0);
    cyc(1, 8'h00, 8'h44, 0);
    cyc(1, 8'h00, 8'h44, 0);
    chk("bp hold F1", 32'(op_a), 32'h3C00);
    cyc(1, 8'h00, 8'h44, 1);
    chk("bp F2 a", 32'(op_a), 32'h4200);
    chk("bp F2 b", 32'(op_b), 32'hC000);
    chk("bp ready back", 32'(byte_ready), 32'd1);
    cyc(1, 8'h00, 8'h44, 0);
    cyc(1, 8'h44, 8'h3C, 1);
    chk("bp F3 a", 32'(op_a), 32'h4400);
    chk("bp F3 b", 32'(op_b), 32'h3C44);
    cyc(0, 8'h00, 8'h00, 1);

    // Timeout after TO idle cycles in HALF
    cyc(1, 8'h11, 8'h22, 1);
    for (int i = 0; i < TO - 1; i++) begin
      cyc(0, 8'h00, 8'h00, 1);
      chk("to early", 32'(err_timeout), 32'd0);
    end
    cyc(0, 8'h00, 8'h00, 1);
    chk("to pulse", 32'(err_timeout), 32'd1);
    chk("to no valid", 32'(op_valid), 32'd0);
    cyc(0, 8'h00, 8'h00, 1);
    chk("to one shot", 32'(err_timeout), 32'd0);
    send(16'h4200, 16'hC400, 1'b1);
    chk("to next a", 32'(op_a), 32'h4200);
    chk("to next b", 32'(op_b), 32'hC400);
    cyc(0, 8'h00, 8'h00, 1);

    // Reset in HALF and with op_valid high
    cyc(1, 8'h00, 8'h00, 1);
    do_reset();
    send(16'h3C00, 16'h3C00, 1'b0);
    chk("pre-rst valid", 32'(op_valid), 32'd1);
    do_reset();
    send(16'h3C00, 16'h3C00, 1'b1);
    chk("post-rst a", 32'(op_a), 32'h3C00);
    chk("post-rst b", 32'(op_b), 32'h3C00);
    chk("post-rst cls", 32'({a_class, b_class}), 32'd0);
    cyc(0, 8'h00, 8'h00, 1);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      int pv, pr;
      pv = (i / 500) % 2 == 0 ? 75 : 40;
      pr = (i / 300) % 3 == 0 ? 20 : 60;
      cyc(($urandom_range(99) < pv), 8'($urandom), 8'($urandom),
          ($urandom_range(99) < pr));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
